// File: rtl/or_sticky_agg.sv
// or_sticky_agg: registered N-channel OR aggregator with sticky pending flags,
// fixed lowest-index-first request offering through an idx/ack handshake,
// and a sticky overflow flag for events that hit an already-pending channel.
module or_sticky_agg #(
    parameter int N    = 4,
    parameter int EDGE = 0,
    localparam int IW  = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [N-1:0]  i,
    input  logic [N-1:0]  mask,
    input  logic [N-1:0]  clr,
    input  logic          ack,
    input  logic          ovf_clr,
    output logic [N-1:0]  pend,
    output logic          q,
    output logic          nq,
    output logic [IW-1:0] idx,
    output logic          valid,
    output logic          ovf
);

    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  i_d_q;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  set_c;
    logic [N-1:0]  req_c;
    logic [N-1:0]  ack_hot_c;
    logic [N-1:0]  clr_eff_c;
    logic [IW-1:0] idx_c;
    logic          valid_c;

    // Channel set condition: raw level, or rising edge against last cycle's input.
    always_comb begin
        set_c = (EDGE != 0) ? (i & ~i_d_q) : i;
    end

    // Lowest-index unmasked pending channel; scanning downward leaves the lowest hit.
    always_comb begin
        req_c   = pend_q & ~mask;
        idx_c   = '0;
        valid_c = 1'b0;
        for (int unsigned k = N; k > 0; k--) begin
            if (req_c[k-1]) begin
                idx_c   = IW'(k - 1);
                valid_c = 1'b1;
            end
        end
    end

    // Effective clears: explicit clr plus the single channel consumed by an accepted ack.
    always_comb begin
        ack_hot_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            ack_hot_c[k] = ack & valid_c & (idx_c == IW'(k));
        end
        clr_eff_c = clr | ack_hot_c;
    end

    // Next-state: a set always wins over a clear; ovf_clr loses to a new overflow.
    always_comb begin
        pend_d = set_c | (pend_q & ~clr_eff_c);
        ovf_d  = (ovf_clr ? 1'b0 : ovf_q) | (|(set_c & pend_q & ~clr_eff_c));
    end

    // State registers with synchronous active-low reset overriding everything.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            pend_q <= '0;
            i_d_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            i_d_q  <= i;
            ovf_q  <= ovf_d;
        end
    end

    assign pend  = pend_q;
    assign q     = valid_c;
    assign nq    = ~valid_c;
    assign idx   = idx_c;
    assign valid = valid_c;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_or_sticky_agg.sv
// Directed bench for or_sticky_agg: three instances cover N=4 level mode,
// N=8 edge mode and N=4 edge mode; all share clk and nrst.
module tb_or_sticky_agg;

    logic clk;
    logic nrst;

    int checks;
    int failures;

    // Instance A: N=4, EDGE=0
    logic [3:0] a_i, a_mask, a_clr, a_pend;
    logic       a_ack, a_ovf_clr, a_q, a_nq, a_valid, a_ovf;
    logic [1:0] a_idx;

    // Instance B: N=8, EDGE=1
    logic [7:0] b_i, b_mask, b_clr, b_pend;
    logic       b_ack, b_ovf_clr, b_q, b_nq, b_valid, b_ovf;
    logic [2:0] b_idx;

    // Instance C: N=4, EDGE=1
    logic [3:0] c_i, c_mask, c_clr, c_pend;
    logic       c_ack, c_ovf_clr, c_q, c_nq, c_valid, c_ovf;
    logic [1:0] c_idx;

    or_sticky_agg #(.N(4), .EDGE(0)) u_a (
        .clk(clk), .nrst(nrst), .i(a_i), .mask(a_mask), .clr(a_clr),
        .ack(a_ack), .ovf_clr(a_ovf_clr), .pend(a_pend), .q(a_q), .nq(a_nq),
        .idx(a_idx), .valid(a_valid), .ovf(a_ovf)
    );

    or_sticky_agg #(.N(8), .EDGE(1)) u_b (
        .clk(clk), .nrst(nrst), .i(b_i), .mask(b_mask), .clr(b_clr),
        .ack(b_ack), .ovf_clr(b_ovf_clr), .pend(b_pend), .q(b_q), .nq(b_nq),
        .idx(b_idx), .valid(b_valid), .ovf(b_ovf)
    );

    or_sticky_agg #(.N(4), .EDGE(1)) u_c (
        .clk(clk), .nrst(nrst), .i(c_i), .mask(c_mask), .clr(c_clr),
        .ack(c_ack), .ovf_clr(c_ovf_clr), .pend(c_pend), .q(c_q), .nq(c_nq),
        .idx(c_idx), .valid(c_valid), .ovf(c_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        a_i  = 4'hF;
        tick();
        tick();
        checks++; if (a_pend !== 4'h0) begin failures++; $display("FAIL reset_pend: got %h expected %h", a_pend, 4'h0); end
        checks++; if (a_q !== 1'b0) begin failures++; $display("FAIL reset_q: got %b expected %b", a_q, 1'b0); end
        checks++; if (a_nq !== 1'b1) begin failures++; $display("FAIL reset_nq: got %b expected %b", a_nq, 1'b1); end
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected %b", a_ovf, 1'b0); end
        checks++; if (a_idx !== 2'd0 || a_valid !== 1'b0) begin failures++; $display("FAIL reset_idx_valid: got %0d/%b expected 0/0", a_idx, a_valid); end
        checks++; if (b_pend !== 8'h00 || b_ovf !== 1'b0) begin failures++; $display("FAIL reset_b: got %h/%b expected 00/0", b_pend, b_ovf); end
        nrst = 1'b1;
        tick();
        checks++; if (a_pend !== 4'hF) begin failures++; $display("FAIL release_pend: got %h expected %h", a_pend, 4'hF); end
        checks++; if (a_q !== 1'b1 || a_idx !== 2'd0) begin failures++; $display("FAIL release_q_idx: got %b/%0d expected 1/0", a_q, a_idx); end
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL release_ovf: got %b expected 0", a_ovf); end
        a_i   = 4'h0;
        a_clr = 4'hF;
        tick();
        a_clr = 4'h0;
        checks++; if (a_pend !== 4'h0 || a_q !== 1'b0) begin failures++; $display("FAIL reset_cleanup: got %h/%b expected 0/0", a_pend, a_q); end
    endtask

    task automatic test_priority_ack();
        b_i = 8'b1010_0100;
        tick();
        b_i = 8'h00;
        checks++; if (b_pend !== 8'hA4) begin failures++; $display("FAIL prio_pend: got %h expected %h", b_pend, 8'hA4); end
        checks++; if (b_idx !== 3'd2 || b_q !== 1'b1) begin failures++; $display("FAIL prio_idx0: got %0d/%b expected 2/1", b_idx, b_q); end
        b_ack = 1'b1;
        tick();
        checks++; if (b_idx !== 3'd5 || b_pend !== 8'hA0) begin failures++; $display("FAIL prio_idx1: got %0d/%h expected 5/a0", b_idx, b_pend); end
        tick();
        checks++; if (b_idx !== 3'd7 || b_pend !== 8'h80) begin failures++; $display("FAIL prio_idx2: got %0d/%h expected 7/80", b_idx, b_pend); end
        tick();
        b_ack = 1'b0;
        checks++; if (b_q !== 1'b0 || b_nq !== 1'b1 || b_pend !== 8'h00) begin failures++; $display("FAIL prio_drained: got q=%b nq=%b pend=%h expected 0/1/00", b_q, b_nq, b_pend); end
        checks++; if (b_ovf !== 1'b0) begin failures++; $display("FAIL prio_ovf: got %b expected 0", b_ovf); end
    endtask

    task automatic test_masking();
        a_i = 4'b0011;
        tick();
        a_i = 4'b0000;
        checks++; if (a_pend !== 4'b0011) begin failures++; $display("FAIL mask_setup: got %b expected 0011", a_pend); end
        a_mask = 4'b0001;
        #1;
        checks++; if (a_idx !== 2'd1 || a_q !== 1'b1 || a_valid !== 1'b1) begin failures++; $display("FAIL mask_one: got idx=%0d q=%b valid=%b expected 1/1/1", a_idx, a_q, a_valid); end
        a_mask = 4'b0011;
        #1;
        checks++; if (a_q !== 1'b0 || a_nq !== 1'b1 || a_idx !== 2'd0) begin failures++; $display("FAIL mask_all: got q=%b nq=%b idx=%0d expected 0/1/0", a_q, a_nq, a_idx); end
        checks++; if (a_pend !== 4'b0011) begin failures++; $display("FAIL mask_pend_kept: got %b expected 0011", a_pend); end
        a_mask = 4'b0000;
        a_clr  = 4'hF;
        tick();
        a_clr = 4'h0;
    endtask

    task automatic test_set_beats_clear();
        a_i = 4'b0001;
        tick();
        checks++; if (a_pend !== 4'b0001) begin failures++; $display("FAIL sbc_setup: got %b expected 0001", a_pend); end
        a_clr = 4'b0001;
        tick();
        checks++; if (a_pend[0] !== 1'b1 || a_ovf !== 1'b0) begin failures++; $display("FAIL sbc_set_wins: got pend0=%b ovf=%b expected 1/0", a_pend[0], a_ovf); end
        a_clr = 4'b0000;
        tick();
        checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL sbc_ovf_set: got %b expected 1", a_ovf); end
        a_i       = 4'b0000;
        a_ovf_clr = 1'b1;
        tick();
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL sbc_ovf_clr: got %b expected 0", a_ovf); end
        a_i = 4'b0001;
        tick();
        a_ovf_clr = 1'b0;
        a_i       = 4'b0000;
        checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL sbc_ovf_set_wins: got %b expected 1", a_ovf); end
        a_ovf_clr = 1'b1;
        a_clr     = 4'hF;
        tick();
        a_ovf_clr = 1'b0;
        a_clr     = 4'h0;
        checks++; if (a_ovf !== 1'b0 || a_pend !== 4'h0) begin failures++; $display("FAIL sbc_cleanup: got ovf=%b pend=%h expected 0/0", a_ovf, a_pend); end
    endtask

    task automatic test_edge_mode();
        c_i = 4'b1000;
        tick();
        checks++; if (c_pend !== 4'b1000) begin failures++; $display("FAIL edge_first: got %b expected 1000", c_pend); end
        tick();
        c_clr = 4'b1000;
        tick();
        c_clr = 4'b0000;
        checks++; if (c_pend !== 4'b0000) begin failures++; $display("FAIL edge_cleared: got %b expected 0000", c_pend); end
        for (int n = 4; n <= 10; n++) begin
            tick();
            checks++; if (c_pend[3] !== 1'b0) begin failures++; $display("FAIL edge_hold_c%0d: got %b expected 0", n, c_pend[3]); end
        end
        checks++; if (c_ovf !== 1'b0) begin failures++; $display("FAIL edge_ovf: got %b expected 0", c_ovf); end
        c_i = 4'b0000;
        tick();
        c_i = 4'b0010;
        tick();
        c_i = 4'b0000;
        checks++; if (c_pend !== 4'b0010 || c_idx !== 2'd1) begin failures++; $display("FAIL edge_pulse: got %b/%0d expected 0010/1", c_pend, c_idx); end
    endtask

    task automatic test_ignored_ack_and_reset();
        a_i = 4'b0011;
        tick();
        a_i    = 4'b0000;
        a_mask = 4'hF;
        a_ack  = 1'b1;
        tick();
        checks++; if (a_pend !== 4'b0011 || a_valid !== 1'b0) begin failures++; $display("FAIL ack_ignored: got pend=%b valid=%b expected 0011/0", a_pend, a_valid); end
        a_ack  = 1'b0;
        a_mask = 4'h0;
        a_i    = 4'hF;
        tick();
        a_i = 4'h0;
        checks++; if (a_pend !== 4'hF || a_ovf !== 1'b1) begin failures++; $display("FAIL midrst_setup: got pend=%h ovf=%b expected f/1", a_pend, a_ovf); end
        a_ack = 1'b1;
        nrst  = 1'b0;
        tick();
        checks++; if (a_pend !== 4'h0 || a_ovf !== 1'b0) begin failures++; $display("FAIL midrst_state: got pend=%h ovf=%b expected 0/0", a_pend, a_ovf); end
        checks++; if (a_q !== 1'b0 || a_nq !== 1'b1 || a_idx !== 2'd0 || a_valid !== 1'b0) begin failures++; $display("FAIL midrst_outs: got q=%b nq=%b idx=%0d valid=%b expected 0/1/0/0", a_q, a_nq, a_idx, a_valid); end
        a_ack = 1'b0;
        nrst  = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        nrst      = 1'b0;
        a_i = '0; a_mask = '0; a_clr = '0; a_ack = 1'b0; a_ovf_clr = 1'b0;
        b_i = '0; b_mask = '0; b_clr = '0; b_ack = 1'b0; b_ovf_clr = 1'b0;
        c_i = '0; c_mask = '0; c_clr = '0; c_ack = 1'b0; c_ovf_clr = 1'b0;
        test_reset();
        test_priority_ack();
        test_masking();
        test_set_beats_clear();
        test_edge_mode();
        test_ignored_ack_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
